// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, key-to-matrix mapping, emulator states and pad indices.
// Pure declarations, no latency.
// No flow control.
package keypad_pkg;

    localparam logic [4:0] KEY_0    = 5'h10;
    localparam logic [4:0] KEY_1    = 5'h11;
    localparam logic [4:0] KEY_2    = 5'h12;
    localparam logic [4:0] KEY_3    = 5'h13;
    localparam logic [4:0] KEY_4    = 5'h14;
    localparam logic [4:0] KEY_5    = 5'h15;
    localparam logic [4:0] KEY_6    = 5'h16;
    localparam logic [4:0] KEY_7    = 5'h17;
    localparam logic [4:0] KEY_8    = 5'h18;
    localparam logic [4:0] KEY_9    = 5'h19;
    localparam logic [4:0] KEY_STAR = 5'h1A;
    localparam logic [4:0] KEY_HASH = 5'h1B;

    // Connector pad numbers for row 0..3 and column 0..2, shared with the scanner.
    localparam int ROW_PAD [4] = '{1, 6, 5, 3};
    localparam int COL_PAD [3] = '{4, 0, 2};

    typedef enum logic [1:0] {IDLE, PRESS, GAP} emu_state_t;

    // Returns {valid, row[1:0], col[1:0]}; all zero for codes outside the keypad.
    function automatic logic [4:0] key_to_rc(input logic [4:0] code);
        logic [4:0] rc;
        rc = 5'b0;
        case (code)
            KEY_3:    rc = {1'b1, 2'd0, 2'd0};
            KEY_2:    rc = {1'b1, 2'd0, 2'd1};
            KEY_1:    rc = {1'b1, 2'd0, 2'd2};
            KEY_6:    rc = {1'b1, 2'd1, 2'd0};
            KEY_5:    rc = {1'b1, 2'd1, 2'd1};
            KEY_4:    rc = {1'b1, 2'd1, 2'd2};
            KEY_9:    rc = {1'b1, 2'd2, 2'd0};
            KEY_8:    rc = {1'b1, 2'd2, 2'd1};
            KEY_7:    rc = {1'b1, 2'd2, 2'd2};
            KEY_HASH: rc = {1'b1, 2'd3, 2'd0};
            KEY_0:    rc = {1'b1, 2'd3, 2'd1};
            KEY_STAR: rc = {1'b1, 2'd3, 2'd2};
            default:  rc = 5'b0;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// Key-code queue: DEPTH x W synchronous FIFO with flush.
// Push visible at dout one cycle later; pop takes effect at the clock edge.
// full/empty come from registered pointers, so a pop never frees a slot in the same cycle.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_emu.sv
// Keypad responder: queued key codes are pressed for HOLD_CYCLES then released for GAP_CYCLES.
// Push to pressed_key: 2 cycles when idle; row_n to col_n: 3 cycles.
// key_ready drops while the queue is full; illegal codes are dropped with an err_invalid pulse.
module keypad_emu
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES = 16384,
    parameter int GAP_CYCLES  = 16384,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       flush,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [4:0] pressed_key,
    output logic       busy,
    output logic       err_invalid
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

    emu_state_t    state;
    logic [CW-1:0] cnt;
    logic [3:0]    row_meta;
    logic [3:0]    row_s;
    logic [4:0]    pk_rc;
    logic [2:0]    col_next;
    logic          code_legal;
    logic          push_acc;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [4:0]    fifo_dout;

    assign key_ready  = reset_n && !fifo_full;
    assign code_legal = (key_code >= KEY_0) && (key_code <= KEY_HASH);
    // flush wins over a same-cycle push or pop.
    assign push_acc   = key_valid && key_ready && !flush;
    assign fifo_pop   = (state == IDLE) && !fifo_empty && !flush;
    assign busy       = (state != IDLE) || !fifo_empty;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (5)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_acc && code_legal),
        .pop     (fifo_pop),
        .flush   (flush),
        .din     (key_code),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pressed_key <= '0;
            err_invalid <= 1'b0;
        end else begin
            err_invalid <= push_acc && !code_legal;
            if (flush) begin
                state       <= IDLE;
                cnt         <= '0;
                pressed_key <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            pressed_key <= fifo_dout;
                            cnt         <= HOLD_LOAD;
                            state       <= PRESS;
                        end
                    end
                    PRESS: begin
                        if (cnt == '0) begin
                            pressed_key <= '0;
                            cnt         <= GAP_LOAD;
                            state       <= GAP;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Any low row that matches the pressed key pulls its column, so multi-row glitches still answer.
    always_comb begin
        pk_rc    = key_to_rc(pressed_key);
        col_next = 3'b111;
        if (pk_rc[4] && !row_s[pk_rc[3:2]]) begin
            col_next[pk_rc[1:0]] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_meta <= '1;
            row_s    <= '1;
            col_n    <= '1;
        end else begin
            row_meta <= row_n;
            row_s    <= row_meta;
            col_n    <= flush ? 3'b111 : col_next;
        end
    end

endmodule

// File: tb/tb_keypad_emu.sv
// Bench for keypad_emu: randomized pushes against a timeline model, a press scoreboard and a row-scanning checker.
module tb_keypad_emu;

    localparam int HOLD  = 48;
    localparam int GAP   = 40;
    localparam int DEPTH = 4;
    localparam int SLOT  = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] key_code = '0;
    logic       key_valid = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] row_n = 4'hF;
    logic       key_ready;
    logic [2:0] col_n;
    logic [4:0] pressed_key;
    logic       busy;
    logic       err_invalid;

    keypad_emu #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .flush       (flush),
        .row_n       (row_n),
        .col_n       (col_n),
        .pressed_key (pressed_key),
        .busy        (busy),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Physical layout of the keypad: keymap[row][col].
    int keymap [4][3] = '{'{'h13, 'h12, 'h11}, '{'h16, 'h15, 'h14},
                          '{'h19, 'h18, 'h17}, '{'h1B, 'h10, 'h1A}};

    function automatic int find_rc(input int code);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3; j++)
                if (keymap[i][j] == code) r = i * 4 + j;
        return r;
    endfunction

    typedef struct { int code; int s; int e; bit ab; } press_t;
    typedef struct { int code; int s; } exp_t;
    typedef struct { int push_t; int pop_t; } pend_t;

    press_t iv[$];
    exp_t   sb[$];
    pend_t  pend[$];
    int     next_free = 0;
    int     busy_until = -1;
    bit     err_due = 1'b0;
    int     ridx = 0;
    bit     glitch_now = 1'b0;
    bit     glitch_req = 1'b0;

    // Timeline model: each accepted legal key is scheduled as a press window [s, s+HOLD) followed by GAP.
    always @(negedge clk) begin : model
        int t, occ, p, s;
        if (chk_en) begin
            t = cyc;
            occ = 0;
            foreach (pend[i]) if (pend[i].push_t < t && pend[i].pop_t >= t) occ++;
            check("key_ready", key_ready, (reset_n && occ < DEPTH));
            check("busy", busy, (occ > 0 || t <= busy_until));
            check("err_invalid", err_invalid, err_due);
            err_due = 1'b0;
            if (!reset_n || flush) begin
                pend.delete();
                for (int i = iv.size() - 1; i >= 0; i--) begin
                    if (iv[i].s > t) iv.delete(i);
                    else if (iv[i].e > t) begin
                        iv[i].e = t + 1;
                        iv[i].ab = 1'b1;
                    end
                end
                for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].s > t) sb.delete(i);
                busy_until = t;
                next_free = t + 1;
            end else if (key_valid && key_ready) begin
                if (key_code >= 5'h10 && key_code <= 5'h1B) begin
                    p = (t + 1 > next_free) ? t + 1 : next_free;
                    s = p + 1;
                    pend.push_back('{t, p});
                    sb.push_back('{int'(key_code), s});
                    iv.push_back('{int'(key_code), s, s + HOLD, 1'b0});
                    busy_until = s + HOLD + GAP - 1;
                    next_free = s + HOLD + GAP;
                end else begin
                    err_due = 1'b1;
                end
            end
            while (pend.size() > 0 && pend[0].pop_t < t) void'(pend.pop_front());
        end
    end

    logic [4:0] prev_pk = '0;
    int cur_s = 0;

    // Monitor: press/release events against the scoreboard, column answers at each scan sample point.
    always @(negedge clk) begin : monitor
        int t, k, ec, rc;
        exp_t ex;
        if (chk_en) begin
            t = cyc;
            if (prev_pk == 0 && pressed_key != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_press", pressed_key, 0);
                end else begin
                    ex = sb.pop_front();
                    check("press_code", pressed_key, ex.code);
                    check("press_start", t, ex.s);
                    cur_s = ex.s;
                end
            end else if (prev_pk != 0 && pressed_key != 0 && pressed_key != prev_pk) begin
                check("press_stable", pressed_key, prev_pk);
            end
            if (prev_pk != 0 && pressed_key == 0) begin
                k = -1;
                foreach (iv[i]) if (iv[i].s == cur_s) k = i;
                if (k < 0) check("release_unknown", t, 0);
                else check("press_end", t, iv[k].e);
            end
            prev_pk = pressed_key;
            if (t % SLOT == SLOT - 2) begin
                ec = 7;
                foreach (iv[i]) begin
                    if (iv[i].s <= t - 1 && t - 1 < (iv[i].ab ? iv[i].e - 1 : iv[i].e)) begin
                        rc = find_rc(iv[i].code);
                        if (glitch_now || rc / 4 == ridx) ec = ec & ~(1 << (rc % 4));
                    end
                end
                check("col_n", col_n, ec);
            end
        end
    end

    // Behavioural scanner: one row low per SLOT cycles, or all rows low while glitching.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc % SLOT == 0) begin
                ridx = (cyc / SLOT) % 4;
                glitch_now = glitch_req;
                row_n = glitch_now ? 4'b0000 : ~(4'b0001 << ridx);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_key(input logic [4:0] c);
        bit acc;
        acc = 1'b0;
        key_code = c;
        key_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            acc = key_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("push_timeout", acc, 1);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busy) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("idle_timeout", hit, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pk(input logic [4:0] c, input int budget);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (pressed_key == c) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) check("press_timeout", hit, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] c;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst_col_n", col_n, 3'b111);
        check("rst_pressed_key", pressed_key, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_invalid, 0);
        check("rst_ready", key_ready, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", key_ready, 1);
        @(posedge clk);
        #1;

        push_key(5'h15);
        wait_idle(400);
        idle(3);

        push_key(5'h11);
        push_key(5'h1B);
        push_key(5'h10);
        wait_idle(800);
        idle(3);

        for (int i = 0; i < 6; i++) push_key(5'($urandom_range(16, 27)));
        wait_idle(1200);
        idle(3);

        push_key(5'h0C);
        push_key(5'h00);
        push_key(5'($urandom_range(28, 31)));
        idle(3);
        check("illegal_busy", busy, 0);
        check("illegal_col", col_n, 3'b111);

        push_key(5'h19);
        push_key(5'($urandom_range(16, 27)));
        push_key(5'($urandom_range(16, 27)));
        wait_pk(5'h19, 200);
        idle(20);
        key_code = 5'h13;
        key_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check("flush_pressed_key", pressed_key, 0);
        check("flush_col_n", col_n, 3'b111);
        check("flush_busy", busy, 0);
        idle(1);
        idle(5);

        push_key(5'h16);
        wait_pk(5'h16, 200);
        idle(10);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_ready", key_ready, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("midrst_col_n", col_n, 3'b111);
        check("midrst_pressed_key", pressed_key, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready_after", key_ready, 1);
        idle(1);
        idle(5);

        glitch_req = 1'b1;
        push_key(5'($urandom_range(16, 27)));
        push_key(5'($urandom_range(16, 27)));
        wait_idle(600);
        glitch_req = 1'b0;

        for (int i = 0; i < 15; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(16, 27));
            push_key(c);
            glitch_req = ($urandom_range(0, 4) == 0);
            idle($urandom_range(0, 100));
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                idle(1);
                flush = 1'b0;
            end
        end
        wait_idle(2000);
        idle(4);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/keypad_emu.md
# keypad_emu

Keypad emulator: the responder end of the 4×3 row-drive/column-sense keypad scan used on the digio bank. It accepts queued key codes over a valid/ready port, fed by the RS232 command path or a test sequencer. It then answers the scanner's active-low row strobes by pulling the matching column low for a programmed hold time, so firmware and bench setups can inject keypresses with no physical keypad. Key codes are the same 5-bit codes the scanner reports.

## Interface
- HOLD_CYCLES, 16384: clk cycles a key stays pressed. Must be ≥ 8192, i.e. two full 4096-cycle scan frames.
- GAP_CYCLES, 16384: clk cycles of release after each press. Must be ≥ 8192.
- FIFO_DEPTH, 4: key-code queue depth, power of 2, ≥ 2.
- clk  in  1  system clock (48 MHz domain)
- reset_n  in  1  reset, synchronous, active-low
- key_code  in  5  key to press; legal 0x10–0x1B
- key_valid  in  1  key_code valid
- key_ready  out  1  queue can accept
- flush  in  1  abort: release key, empty queue
- row_n  in  4  scanner row drives, active low; bit 0..3 = row 0..3 (pads 1,6,5,3); asynchronous
- col_n  out  3  column pulls, active low; bit 0..2 = col 0..2 (pads 4,0,2)
- pressed_key  out  5  code currently pressed, 0x00 when none
- busy  out  1  queue non-empty or press/gap in progress
- err_invalid  out  1  one-cycle pulse: illegal code dropped

## Operation
- Key map (row,col)→code:
  - col 0: 0x13, 0x16, 0x19, 0x1B for rows 0–3.
  - col 1: 0x12, 0x15, 0x18, 0x10 for rows 0–3.
  - col 2: 0x11, 0x14, 0x17, 0x1A for rows 0–3.
- Push handshake:
  - A push happens when key_valid && key_ready.
  - key_ready = reset_n && !full. It is combinational from registered full.
  - A legal code is enqueued.
  - An illegal code (outside 0x10–0x1B, including 0x00) is not enqueued; err_invalid pulses on the next cycle.
- FSM states: IDLE, PRESS, GAP.
  - IDLE: if the queue is non-empty, pop, latch the code into pressed_key, load cnt = HOLD_CYCLES-1, go to PRESS.
  - PRESS: decrement cnt. At cnt==0, set pressed_key = 0, load cnt = GAP_CYCLES-1, go to GAP.
  - GAP: decrement cnt. At cnt==0, go to IDLE.
- Column response:
  - row_n passes through a 2-FF synchronizer to give row_s.
  - col_n[c] is registered: 0 when pressed_key maps to (r,c) and row_s[r]==0; otherwise 1.
  - Unpressed columns are always 1.
- flush: at the next edge the FSM goes to IDLE, pressed_key = 0, and the queue empties. flush has priority over a same-cycle push (the push is dropped, with no err pulse) and over a same-cycle pop.
- Counter width: $clog2(max(HOLD_CYCLES,GAP_CYCLES)) bits, unsigned.
- busy = (state != IDLE) || !empty.

## Timing
- Reset values: col_n = 3'b111, pressed_key = 0, busy = 0, err_invalid = 0, key_ready = 0; FSM in IDLE with the queue empty.
- row_n edge to col_n change: 3 clk cycles (2 synchronizer + 1 output register).
- Push in cycle t with the FSM IDLE and the queue empty: pop in t+1, pressed_key valid from t+2.
- Press lasts exactly HOLD_CYCLES cycles and the gap exactly GAP_CYCLES cycles.
- Back-to-back keys: one key every 1+HOLD_CYCLES+GAP_CYCLES cycles.
- Queue full: key_ready low. A pop in the same cycle does not raise ready until the next cycle (no full-bypass).
- reset_n low mid-press: all outputs take their reset values at that edge and the queue is discarded.
- row_n with more than one row low (bus glitch): col_n follows any matching low row; no error.

## Structure
- keypad_pkg:
  - KEY_* code constants.
  - key_to_rc() function returning {valid, row[1:0], col[1:0]}.
  - typedef enum logic [1:0] {IDLE, PRESS, GAP} emu_state_t.
  - Row/col pad-index constants shared with the scanner.
- Sub-module: key_fifo, a synchronous FIFO of FIFO_DEPTH entries × 5 bits with push/pop/flush and full/empty.
- Synchronizer inline, 2 FFs per row bit.

## Test plan
Scenarios use HOLD_CYCLES=8192, GAP_CYCLES=8192, with a behavioural scanner (rows cycled every 1024 clk, columns sampled at offset 0x3F0).
- Push 0x15 once → pressed_key=0x15 from t+2 for 8192 cycles. col_n[1]=0 only while row 1 is low (+3 cycles). The scanner reports 0x15.
- Push 0x11, 0x1B, 0x10 back to back → the scanner reports 0x11, 0x1B, 0x10 in order, starts 16385 cycles apart. busy falls after the final gap.
- Push 5 codes into an idle block, with key_valid held → key_ready drops when 4 are queued. The 5th is accepted only after the first pop. All 5 are reported.
- Push 0x0C and 0x00 → neither is enqueued; err_invalid pulses once per code; col_n stays 111; busy stays 0.
- flush 100 cycles into a press of 0x19 with 2 codes queued → next edge: pressed_key=0, col_n=111, busy=0. A same-cycle push of 0x13 is dropped.
- reset_n low mid-press for 1 cycle → col_n=111, pressed_key=0, key_ready=0 during reset. After release the queue is empty and key_ready=1.
